exc_vector_mux: RTL

//  Parametrised successor of the PC-source selector in the multicycle MIPS datapath.

---
 rtl/exc_vector_mux.sv | 115 +++++++++++
 1 files changed

// File: rtl/exc_vector_mux.sv
// Registered N-way PC-source selector with exception entry: on a request it
// issues the vector byte read, then presents the zero-extended handler address.
module exc_vector_mux #(
    parameter int  WIDTH    = 32,
    parameter int  N_DATA   = 4,
    parameter int  N_EXC    = 3,
    parameter int  VEC_BASE = 253,
    parameter int  MEM_LAT  = 1,
    localparam int SW       = (N_DATA > 1) ? $clog2(N_DATA) : 1,
    localparam int EW       = (N_EXC > 1) ? $clog2(N_EXC) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SW-1:0]             sel,
    input  logic [N_DATA*WIDTH-1:0]   data_in,
    input  logic [N_EXC-1:0]          exc_req,
    input  logic [7:0]                mem_byte,
    output logic [WIDTH-1:0]          data_out,
    output logic                      mem_rd,
    output logic                      busy,
    output logic                      exc_done,
    output logic [EW-1:0]             exc_cause
);

    localparam int CW  = $clog2(MEM_LAT + 1);
    localparam int NCH = 1 << SW;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             mem_rd_nxt, busy_nxt, done_nxt;
    logic [EW-1:0]    cause_nxt;
    logic [EW-1:0]    exc_idx;
    logic [WIDTH-1:0] vec_addr;
    logic [WIDTH-1:0] chan [NCH];

    // Select codes with no physical channel behind them fold onto channel 0.
    for (genvar k = 0; k < NCH; k++) begin : g_chan
        if (k < N_DATA) begin : g_real
            assign chan[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_fold
            assign chan[k] = data_in[WIDTH-1:0];
        end
    end

    // Downward scan so the lowest set bit wins.
    always_comb begin
        exc_idx = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (exc_req[i]) exc_idx = EW'(i);
        end
    end

    assign vec_addr = WIDTH'(VEC_BASE) + WIDTH'(exc_idx);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dout_nxt   = data_out;
        mem_rd_nxt = mem_rd;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        cause_nxt  = exc_cause;
        case (state)
            IDLE: begin
                if (exc_req != '0) begin
                    cause_nxt  = exc_idx;
                    dout_nxt   = vec_addr;
                    mem_rd_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = CW'(MEM_LAT);
                    state_nxt  = WAIT;
                end else begin
                    dout_nxt = chan[sel];
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    dout_nxt   = WIDTH'(mem_byte);
                    mem_rd_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset also aborts an outstanding vector read, so no exc_done follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            data_out  <= '0;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            exc_done  <= 1'b0;
            exc_cause <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            data_out  <= dout_nxt;
            mem_rd    <= mem_rd_nxt;
            busy      <= busy_nxt;
            exc_done  <= done_nxt;
            exc_cause <= cause_nxt;
        end
    end

endmodule
